muldiv_unit: RTL and testbench

Multi-cycle, parametrised RISC-V M-extension unit (RV32M/RV64M) sitting beside the single-cycle ALU in the execute stage. The ALU keeps every single-cycle op. All multiply, divide and remainder codes are routed here instead.
- Each op runs as an iterative shift-add / shift-subtract sequence behind a valid/ready handshake, so the execute stage stalls only on M-ops.
- The unit applies the architected divide-by-zero and signed-overflow results.

---
 rtl/muldiv_unit_pkg.sv | 40 ++++
 rtl/muldiv_unit_if.sv | 26 ++
 rtl/muldiv_unit_step.sv | 44 ++++
 rtl/muldiv_unit.sv | 260 ++++++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the M-extension multiply/divide unit.
//   - Opcode values from the shared decode table (8-bit codes).
//   - FSM state encoding and result-select encoding.
//   - is_word_op(): true for the 32-bit W-suffixed operations.
package muldiv_unit_pkg;

    localparam logic [7:0] OP_MUL    = 8'd10;
    localparam logic [7:0] OP_MULH   = 8'd11;
    localparam logic [7:0] OP_MULHSU = 8'd12;
    localparam logic [7:0] OP_MULHU  = 8'd13;
    localparam logic [7:0] OP_DIV    = 8'd14;
    localparam logic [7:0] OP_DIVU   = 8'd15;
    localparam logic [7:0] OP_REM    = 8'd16;
    localparam logic [7:0] OP_REMU   = 8'd17;
    localparam logic [7:0] OP_MULW   = 8'd38;
    localparam logic [7:0] OP_DIVW   = 8'd39;
    localparam logic [7:0] OP_DIVUW  = 8'd40;
    localparam logic [7:0] OP_REMW   = 8'd41;
    localparam logic [7:0] OP_REMUW  = 8'd42;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_e;

    // Which part of the iteration registers forms the result.
    typedef enum logic [1:0] {
        SEL_MUL_LO,
        SEL_MUL_HI,
        SEL_QUO,
        SEL_REM
    } res_sel_e;

    function automatic logic is_word_op(input logic [7:0] op);
        return (op == OP_MULW)  || (op == OP_DIVW) || (op == OP_DIVUW) ||
               (op == OP_REMW)  || (op == OP_REMUW);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and muldiv_unit.
//   master: issues in_valid/instruction/rs1/rs2/flush, accepts with out_ready.
//   slave : the unit; returns in_ready, out_valid and result.
interface muldiv_unit_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [7:0]      instruction;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    modport master (
        output in_valid, instruction, rs1, rs2, flush, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, instruction, rs1, rs2, flush, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/muldiv_unit_step.sv
// muldiv_step: one combinational iteration of the shift-add multiplier or the
// restoring divider, operating on a {hi, lo} register pair.
//   is_div  : 1 = divide step, 0 = multiply step
//   hi, lo  : current iteration state
//               multiply: hi = partial product, lo = remaining multiplier bits
//               divide  : hi = partial remainder, lo = dividend/quotient shifter
//   opnd    : multiplicand (multiply) or divisor (divide) magnitude
//   hi_next, lo_next : state after this iteration
module muldiv_step #(
    parameter int XLEN = 64
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] opnd,
    output logic [XLEN-1:0] hi_next,
    output logic [XLEN-1:0] lo_next
);
    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        // Multiply: add multiplicand when the current multiplier bit is set,
        // then shift the whole {carry, hi, lo} right by one.
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        // Divide: bring the next dividend bit into the remainder and trial
        // subtract. A set top bit of diff means the subtract borrowed.
        shifted = {hi, lo[XLEN-1]};
        diff    = shifted - {1'b0, opnd};
        if (is_div) begin
            if (!diff[XLEN]) begin
                hi_next = diff[XLEN-1:0];
                lo_next = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_next = shifted[XLEN-1:0];
                lo_next = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_next = sum[XLEN:1];
            lo_next = {sum[0], lo[XLEN-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide/remainder unit.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, returns the unit to IDLE
//   bus   : muldiv_unit_if slave port (request handshake, flush,
//           registered result handshake)
// One op at a time: IDLE accepts, CALC runs N single-bit iterations
// (N = XLEN, or 32 for W ops), DONE registers the result and holds it until
// the consumer takes it. Divide-by-zero, signed overflow and unknown opcodes
// skip CALC and go straight to DONE.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 64
) (
    input logic          clk,
    input logic          reset,
    muldiv_unit_if.slave bus
);
    localparam int              CW        = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST_FULL = CW'(XLEN - 1);
    localparam logic [CW-1:0]   LAST_WORD = CW'(31);
    localparam int              WSHIFT    = XLEN - 32;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic signed [31:0]     s;
        logic signed [XLEN-1:0] x;
        s = v;
        x = s;
        return x;
    endfunction

    // Control state
    state_e          state;
    logic [CW-1:0]   cnt;
    logic            in_ready_q;
    logic            out_valid_q;
    logic [XLEN-1:0] result_q;

    // Captured op and iteration registers (no reset needed: only read
    // after an accept has loaded them)
    logic            word_q;
    logic            is_div_q;
    logic            fast_q;
    logic            neg_q;
    res_sel_e        sel_q;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] opnd_q;

    // Decode
    logic            known;
    logic            word;
    logic            is_div;
    logic            a_signed;
    logic            b_signed;
    res_sel_e        sel;

    // Operand preparation and special cases
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic [XLEN-1:0] min_val;
    logic            div_zero;
    logic            ovf;
    logic            fast;
    logic            neg;
    logic [XLEN-1:0] fast_val;
    logic            accept;

    // Result formation
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   lo_w;
    logic [XLEN-1:0]   final_val;

    logic [XLEN-1:0] hi_n;
    logic [XLEN-1:0] lo_n;

    assign accept = bus.in_valid & in_ready_q & ~bus.flush;

    always_comb begin
        known    = 1'b1;
        word     = is_word_op(bus.instruction);
        is_div   = 1'b0;
        a_signed = 1'b0;
        b_signed = 1'b0;
        sel      = SEL_MUL_LO;
        case (bus.instruction)
            OP_MUL:    sel = SEL_MUL_LO;
            OP_MULH:   begin sel = SEL_MUL_HI; a_signed = 1'b1; b_signed = 1'b1; end
            OP_MULHSU: begin sel = SEL_MUL_HI; a_signed = 1'b1; end
            OP_MULHU:  sel = SEL_MUL_HI;
            OP_DIV:    begin sel = SEL_QUO; is_div = 1'b1; a_signed = 1'b1; b_signed = 1'b1; end
            OP_DIVU:   begin sel = SEL_QUO; is_div = 1'b1; end
            OP_REM:    begin sel = SEL_REM; is_div = 1'b1; a_signed = 1'b1; b_signed = 1'b1; end
            OP_REMU:   begin sel = SEL_REM; is_div = 1'b1; end
            OP_MULW:   sel = SEL_MUL_LO;
            OP_DIVW:   begin sel = SEL_QUO; is_div = 1'b1; a_signed = 1'b1; b_signed = 1'b1; end
            OP_DIVUW:  begin sel = SEL_QUO; is_div = 1'b1; end
            OP_REMW:   begin sel = SEL_REM; is_div = 1'b1; a_signed = 1'b1; b_signed = 1'b1; end
            OP_REMUW:  begin sel = SEL_REM; is_div = 1'b1; end
            default:   known = 1'b0;
        endcase
        // W ops exist only on a 64-bit datapath.
        if (word && (XLEN != 64)) known = 1'b0;
    end

    always_comb begin
        if (word) begin
            opa = a_signed ? sext32(bus.rs1[31:0]) : XLEN'(bus.rs1[31:0]);
            opb = b_signed ? sext32(bus.rs2[31:0]) : XLEN'(bus.rs2[31:0]);
        end else begin
            opa = bus.rs1;
            opb = bus.rs2;
        end
        a_neg = a_signed & opa[XLEN-1];
        b_neg = b_signed & opb[XLEN-1];
        mag_a = a_neg ? -opa : opa;
        mag_b = b_neg ? -opb : opb;

        // In W form the most negative value is the sign-extended 32-bit one.
        min_val  = word ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = is_div & (opb == '0);
        ovf      = is_div & a_signed & (opa == min_val) & (opb == '1);
        fast     = ~known | div_zero | ovf;

        fast_val = '0;
        if (known && div_zero) begin
            if (sel == SEL_QUO) fast_val = '1;
            else                fast_val = word ? sext32(bus.rs1[31:0]) : bus.rs1;
        end else if (known && ovf) begin
            if (sel == SEL_QUO) fast_val = opa;
            else                fast_val = '0;
        end

        case (sel)
            SEL_MUL_HI: neg = a_neg ^ b_neg;
            SEL_QUO:    neg = a_neg ^ b_neg;
            SEL_REM:    neg = a_neg;
            default:    neg = 1'b0;
        endcase
    end

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div  (is_div_q),
        .hi      (hi_q),
        .lo      (lo_q),
        .opnd    (opnd_q),
        .hi_next (hi_n),
        .lo_next (lo_n)
    );

    // Sign restore and W-op extension applied once the iterations finish.
    always_comb begin
        prod   = {hi_q, lo_q};
        prod_s = neg_q ? -prod : prod;
        quo_s  = neg_q ? -lo_q : lo_q;
        rem_s  = neg_q ? -hi_q : hi_q;
        // After 32 multiply steps the low product word sits in the top half of lo.
        lo_w   = lo_q >> WSHIFT;
        final_val = '0;
        if (fast_q) begin
            final_val = lo_q;
        end else begin
            case (sel_q)
                SEL_MUL_LO: final_val = word_q ? sext32(lo_w[31:0]) : lo_q;
                SEL_MUL_HI: final_val = prod_s[2*XLEN-1:XLEN];
                SEL_QUO:    final_val = word_q ? sext32(quo_s[31:0]) : quo_s;
                SEL_REM:    final_val = word_q ? sext32(rem_s[31:0]) : rem_s;
                default:    final_val = '0;
            endcase
        end
    end

    // Capture stage: load magnitudes / fast result; CALC: one step per cycle.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && accept) begin
            word_q   <= word;
            is_div_q <= is_div;
            fast_q   <= fast;
            neg_q    <= neg;
            sel_q    <= sel;
            hi_q     <= '0;
            if (fast) begin
                lo_q   <= fast_val;
                opnd_q <= '0;
            end else if (is_div) begin
                // W dividends are left-justified so 32 steps consume them fully.
                lo_q   <= word ? (mag_a << WSHIFT) : mag_a;
                opnd_q <= mag_b;
            end else begin
                lo_q   <= mag_b;
                opnd_q <= mag_a;
            end
        end else if (state == ST_CALC) begin
            hi_q <= hi_n;
            lo_q <= lo_n;
        end
    end

    // FSM with registered handshake outputs. out_valid is raised one cycle
    // after entering DONE, the same cycle result is written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cnt        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= fast ? ST_DONE : ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (bus.flush) begin
                        state      <= ST_IDLE;
                        in_ready_q <= 1'b1;
                    end else if (cnt == (word_q ? LAST_WORD : LAST_FULL)) begin
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.flush) begin
                        state       <= ST_IDLE;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end else if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        result_q    <= final_val;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= ST_IDLE;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit (XLEN = 64).
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    muldiv_unit_if #(.XLEN(64)) bus ();

    muldiv_unit #(.XLEN(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Present one request, wait for out_valid; lat = edges after the accept edge.
    task automatic issue(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b,
                         output int lat, output logic [63:0] res);
        @(negedge clk);
        bus.instruction = op;
        bus.rs1 = a;
        bus.rs2 = b;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        res = bus.result;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        tests_run++;
        if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        tests_run++;
        if (bus.result !== 64'd0) begin tests_failed++; $display("FAIL reset_result: got %h want 0", bus.result); end
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_mul();
        int lat;
        logic [63:0] res;
        issue(OP_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, lat, res);
        tests_run++;
        if (res !== 64'hFFFF_FFFF_FFFF_FFEB) begin tests_failed++; $display("FAIL mul_7x-3: got %h want ffffffffffffffeb", res); end
        tests_run++;
        if (lat != 65) begin tests_failed++; $display("FAIL mul_latency: got %0d want 65", lat); end
        drain();
        issue(OP_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, lat, res);
        tests_run++;
        if (res !== 64'hFFFF_FFFF_FFFF_FFFE) begin tests_failed++; $display("FAIL mulhu_max: got %h want fffffffffffffffe", res); end
        drain();
        issue(OP_MULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, lat, res);
        tests_run++;
        if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin tests_failed++; $display("FAIL mulh_-1x2: got %h want ffffffffffffffff", res); end
        drain();
        issue(OP_MULHSU, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, lat, res);
        tests_run++;
        if (res !== 64'd1) begin tests_failed++; $display("FAIL mulhsu_2xmax: got %h want 1", res); end
        drain();
    endtask

    task automatic test_div();
        int lat;
        logic [63:0] res;
        issue(OP_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, lat, res);
        tests_run++;
        if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin tests_failed++; $display("FAIL div_-7/2: got %h want fffffffffffffffd", res); end
        tests_run++;
        if (lat != 65) begin tests_failed++; $display("FAIL div_latency: got %0d want 65", lat); end
        drain();
        issue(OP_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, lat, res);
        tests_run++;
        if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin tests_failed++; $display("FAIL rem_-7/2: got %h want ffffffffffffffff", res); end
        drain();
        issue(OP_DIVU, 64'd100, 64'd7, lat, res);
        tests_run++;
        if (res !== 64'd14) begin tests_failed++; $display("FAIL divu_100/7: got %h want e", res); end
        drain();
        issue(OP_REMU, 64'd100, 64'd7, lat, res);
        tests_run++;
        if (res !== 64'd2) begin tests_failed++; $display("FAIL remu_100/7: got %h want 2", res); end
        drain();
    endtask

    task automatic test_div_zero();
        int lat;
        logic [63:0] res;
        issue(OP_DIV, 64'd5, 64'd0, lat, res);
        tests_run++;
        if (res !== 64'hFFFF_FFFF_FFFF_FFFF || lat != 1) begin tests_failed++; $display("FAIL div_5/0: got %h lat %0d want ffffffffffffffff lat 1", res, lat); end
        drain();
        issue(OP_REMU, 64'd5, 64'd0, lat, res);
        tests_run++;
        if (res !== 64'd5 || lat != 1) begin tests_failed++; $display("FAIL remu_5/0: got %h lat %0d want 5 lat 1", res, lat); end
        drain();
        issue(OP_DIVUW, 64'd5, 64'hFFFF_FFFF_0000_0000, lat, res);
        tests_run++;
        if (res !== 64'hFFFF_FFFF_FFFF_FFFF || lat != 1) begin tests_failed++; $display("FAIL divuw_5/0: got %h lat %0d want ffffffffffffffff lat 1", res, lat); end
        drain();
        issue(8'd20, 64'd9, 64'd3, lat, res);
        tests_run++;
        if (res !== 64'd0 || lat != 1) begin tests_failed++; $display("FAIL unknown_op: got %h lat %0d want 0 lat 1", res, lat); end
        drain();
    endtask

    task automatic test_overflow();
        int lat;
        logic [63:0] res;
        issue(OP_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, lat, res);
        tests_run++;
        if (res !== 64'h8000_0000_0000_0000 || lat != 1) begin tests_failed++; $display("FAIL div_ovf: got %h lat %0d want 8000000000000000 lat 1", res, lat); end
        drain();
        issue(OP_REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, lat, res);
        tests_run++;
        if (res !== 64'd0) begin tests_failed++; $display("FAIL rem_ovf: got %h want 0", res); end
        drain();
        issue(OP_DIVW, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, lat, res);
        tests_run++;
        if (res !== 64'hFFFF_FFFF_8000_0000) begin tests_failed++; $display("FAIL divw_ovf: got %h want ffffffff80000000", res); end
        drain();
        issue(OP_DIVUW, 64'hABCD_0000_0000_0064, 64'd7, lat, res);
        tests_run++;
        if (res !== 64'd14 || lat != 33) begin tests_failed++; $display("FAIL divuw_100/7: got %h lat %0d want e lat 33", res, lat); end
        drain();
    endtask

    task automatic test_mulw_backpressure();
        int lat;
        logic [63:0] res;
        issue(OP_MULW, 64'h0000_0000_0001_0000, 64'h0000_0000_0000_8000, lat, res);
        tests_run++;
        if (res !== 64'hFFFF_FFFF_8000_0000) begin tests_failed++; $display("FAIL mulw: got %h want ffffffff80000000", res); end
        tests_run++;
        if (lat != 33) begin tests_failed++; $display("FAIL mulw_latency: got %0d want 33", lat); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests_run++;
            if (bus.result !== 64'hFFFF_FFFF_8000_0000 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL backpressure_hold: cycle %0d result %h in_ready %b out_valid %b", i, bus.result, bus.in_ready, bus.out_valid);
            end
        end
        drain();
        tests_run++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL after_handshake: in_ready %b out_valid %b want 1 0", bus.in_ready, bus.out_valid); end
        tests_run++;
        if (bus.result !== 64'hFFFF_FFFF_8000_0000) begin tests_failed++; $display("FAIL idle_hold: got %h want ffffffff80000000", bus.result); end
    endtask

    task automatic test_flush();
        int seen;
        @(negedge clk);
        bus.instruction = OP_DIV;
        bus.rs1 = 64'd1000;
        bus.rs2 = 64'd3;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        tests_run++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_calc: in_ready %b out_valid %b want 1 0", bus.in_ready, bus.out_valid); end
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen++;
        end
        tests_run++;
        if (seen != 0) begin tests_failed++; $display("FAIL flush_no_result: out_valid seen %0d want 0", seen); end
        // Request presented together with flush in IDLE must be ignored.
        bus.instruction = OP_DIV;
        bus.rs1 = 64'd5;
        bus.rs2 = 64'd0;
        bus.in_valid = 1'b1;
        bus.flush = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.flush = 1'b0;
        tests_run++;
        if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_idle_accept: in_ready %b want 1", bus.in_ready); end
        repeat (3) @(negedge clk);
        tests_run++;
        if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_idle_result: out_valid %b want 0", bus.out_valid); end
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        logic [63:0] res;
        issue(OP_DIVU, 64'd100, 64'd7, lat, res);
        tests_run++;
        if (res !== 64'd14) begin tests_failed++; $display("FAIL pre_reset_divu: got %h want e", res); end
        drain();
        @(negedge clk);
        bus.instruction = OP_DIV;
        bus.rs1 = 64'd1000;
        bus.rs2 = 64'd3;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (20) @(negedge clk);
        reset = 1'b1;
        #1;
        tests_run++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== 64'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_calc: in_ready %b out_valid %b result %h want 1 0 0", bus.in_ready, bus.out_valid, bus.result);
        end
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen++;
        end
        tests_run++;
        if (seen != 0) begin tests_failed++; $display("FAIL reset_no_result: out_valid seen %0d want 0", seen); end
        issue(OP_REMU, 64'd100, 64'd7, lat, res);
        tests_run++;
        if (res !== 64'd2 || lat != 65) begin tests_failed++; $display("FAIL after_reset_remu: got %h lat %0d want 2 lat 65", res, lat); end
        drain();
    endtask

    initial begin
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.instruction = 8'd0;
        bus.rs1 = 64'd0;
        bus.rs2 = 64'd0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_mul();
        test_div();
        test_div_zero();
        test_overflow();
        test_mulw_backpressure();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
